// File: rtl/isqrt_stream_frontend.sv
// Streaming front end for the inverse-square-root core: input FIFO, issue stage,
// tag delay line and output stage. Define ISQRT_SPECIAL_CASE_EN for local IEEE special-case handling.

package isqrt_stream_frontend_pkg;

    localparam logic [31:0] FP_ONE = 32'h3F80_0000;

`ifdef ISQRT_SPECIAL_CASE_EN
    typedef struct packed {
        logic       valid;
        logic [1:0] cls;
        logic       sign;
    } tag_t;
`else
    typedef struct packed {
        logic valid;
    } tag_t;
`endif

endpackage

module isqrt_stream_frontend
    import isqrt_stream_frontend_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [31:0]              core_data,
    input  logic [31:0]              core_result,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    output logic [1:0]               out_class,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

`ifdef ISQRT_SPECIAL_CASE_EN
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

    // 0 normal, 1 zero/denormal, 2 +inf, 3 NaN or negative nonzero
    function automatic logic [1:0] classify(input logic [31:0] x);
        logic [7:0]  e;
        logic [22:0] m;
        e = x[30:23];
        m = x[22:0];
        if (e == 8'h00)                        return 2'd1;
        else if (e == 8'hFF && m != 23'd0)     return 2'd3;
        else if (e == 8'hFF && !x[31])         return 2'd2;
        else if (x[31])                        return 2'd3;
        else                                   return 2'd0;
    endfunction
`endif

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_c, pop_c;
    logic [31:0]   head_c;

    logic [31:0]   core_data_q, core_data_d;
    tag_t          issue_tag_d;
    tag_t          tag_q [0:LATENCY];

    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_data_q, out_data_d;

    assign in_ready   = rst && (level_q < LW'(DEPTH));
    assign push_c     = in_valid && in_ready;
    assign pop_c      = (level_q != LW'(0));
    assign head_c     = mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign core_data  = core_data_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Issue stage: bubbles and special operands feed the core a harmless 1.0
    always_comb begin
        core_data_d = FP_ONE;
        issue_tag_d = '0;
        if (pop_c) begin
            issue_tag_d.valid = 1'b1;
`ifdef ISQRT_SPECIAL_CASE_EN
            issue_tag_d.cls  = classify(head_c);
            issue_tag_d.sign = head_c[31];
            if (issue_tag_d.cls == 2'd0) core_data_d = head_c;
`else
            core_data_d = head_c;
`endif
        end
    end

`ifdef ISQRT_SPECIAL_CASE_EN
    logic [1:0] out_class_q, out_class_d;
    assign out_class = out_class_q;

    // Output stage: substitute special-case results, hold during bubbles
    always_comb begin
        out_valid_d = tag_q[LATENCY].valid;
        out_data_d  = out_data_q;
        out_class_d = out_class_q;
        if (tag_q[LATENCY].valid) begin
            out_class_d = tag_q[LATENCY].cls;
            case (tag_q[LATENCY].cls)
                2'd0:    out_data_d = core_result;
                2'd1:    out_data_d = tag_q[LATENCY].sign ? FP_NEG_INF : FP_POS_INF;
                2'd2:    out_data_d = 32'h0000_0000;
                default: out_data_d = FP_QNAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_class_q <= 2'd0;
        else      out_class_q <= out_class_d;
    end
`else
    assign out_class = 2'd0;

    // Output stage: pass core result through, hold during bubbles
    always_comb begin
        out_valid_d = tag_q[LATENCY].valid;
        out_data_d  = out_data_q;
        if (tag_q[LATENCY].valid) out_data_d = core_result;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int unsigned i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            core_data_q <= FP_ONE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (push_c) mem_q[wr_ptr_q] <= in_data;
            tag_q[0] <= issue_tag_d;
            for (int unsigned i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            core_data_q <= core_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_isqrt_stream_frontend.sv
// Scoreboard bench for isqrt_stream_frontend with a fixed-latency core model.
// Expected values follow ISQRT_SPECIAL_CASE_EN the same way the design build does.

module tb_isqrt_stream_frontend;

    localparam int DEPTH = 4;
    localparam int LAT   = 6;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  cls;
        int          acc;
    } exp_t;

    logic        clk, rst;
    logic [31:0] in_data, core_data, core_result, out_data;
    logic        in_valid, in_ready, out_valid;
    logic [1:0]  out_class;
    logic [$clog2(DEPTH):0] fifo_level;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    logic [31:0] core_pipe [LAT];

    isqrt_stream_frontend #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .core_data(core_data), .core_result(core_result), .out_data(out_data),
        .out_valid(out_valid), .out_class(out_class), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in core: magic-constant inverse sqrt estimate, LAT cycles after core_data updates
    function automatic logic [31:0] core_fn(input logic [31:0] x);
        return 32'h5F37_59DF - {1'b0, x[31:1]};
    endfunction

    initial for (int i = 0; i < LAT; i++) core_pipe[i] = 32'h3F80_0000;
    always @(posedge clk) begin
        core_pipe[0] <= core_data;
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_result = core_fn(core_pipe[LAT-1]);

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, got, want, cyc);
        end
    endfunction

    // Monitor: handshake invariant every cycle, scoreboard pop on every output
    always @(negedge clk) begin
        chk("in_ready_rule", 32'(in_ready), 32'(rst && (fifo_level < DEPTH)));
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_class", 32'(out_class), 32'(e.cls));
                chk("latency", 32'(cyc - e.acc), 32'(LAT + 2));
            end
        end
    end

    task automatic push(input logic [31:0] x, input logic [31:0] d, input logic [1:0] c);
        exp_t e;
        @(negedge clk);
        in_data  = x;
        in_valid = 1'b1;
        chk("in_ready_at_push", 32'(in_ready), 32'd1);
        chk("fifo_level_le1", 32'(fifo_level <= 1), 32'd1);
        for (int n = 0; !in_ready && n < 20; n++) @(negedge clk);
        e.data = d;
        e.cls  = c;
        e.acc  = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
        chk("drain_pending", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_class", 32'(out_class), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_core_data", core_data, 32'h3F80_0000);
    endtask

    localparam logic [31:0] SP_X  [6] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001,
                                          32'h7F80_0000, 32'hC000_0000, 32'h7FC1_2345};
`ifdef ISQRT_SPECIAL_CASE_EN
    localparam logic [31:0] SP_D  [6] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000,
                                          32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000};
    localparam logic [1:0]  SP_C  [6] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    localparam logic [31:0] NEG_D     = 32'h7FC0_0000;
    localparam logic [1:0]  NEG_C     = 2'd3;
    localparam logic [31:0] NEG_CORE  = 32'h3F80_0000;
`else
    localparam logic [31:0] SP_D  [6] = '{32'h5F37_59DF, 32'h1F37_59DF, 32'h5F37_59DF,
                                          32'h1F77_59DF, 32'hFF37_59DF, 32'h1F56_C83D};
    localparam logic [1:0]  SP_C  [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [31:0] NEG_D     = 32'hFF37_59DF;
    localparam logic [1:0]  NEG_C     = 2'd0;
    localparam logic [31:0] NEG_CORE  = 32'hC000_0000;
`endif

    initial begin
        logic [31:0] x;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b1;
        #1 chk("in_ready_after_release", 32'(in_ready), 32'd1);

        // Single normal operand, no fall-through, then issue one edge later
        push(32'h4080_0000, 32'h3EF7_59DF, 2'd0);
        idle();
        chk("level_after_push", 32'(fifo_level), 32'd1);
        chk("core_data_not_yet", core_data, 32'h3F80_0000);
        @(posedge clk);
        #1;
        chk("core_data_issue", core_data, 32'h4080_0000);
        chk("level_after_pop", 32'(fifo_level), 32'd0);
        drain();

        // Special-case operands back to back
        for (int i = 0; i < 6; i++) push(SP_X[i], SP_D[i], SP_C[i]);
        idle();
        drain();

        // Reset pulse, then 10 continuous pushes
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x = 32'h3F80_0000 + (32'(i) << 20);
            push(x, core_fn(x), 2'd0);
        end
        idle();
        drain();

        // Negative operand: core sees substitute or raw value one edge after accept
        push(32'hC000_0000, NEG_D, NEG_C);
        idle();
        @(posedge clk);
        #1 chk("core_data_neg", core_data, NEG_CORE);
        drain();

        // Reset while three operands are in flight
        push(32'h3F80_0000, 32'h3F77_59DF, 2'd0);
        push(32'h4080_0000, 32'h3EF7_59DF, 2'd0);
        push(32'h3F80_0000, 32'h3F77_59DF, 2'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        #1 check_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("in_ready_after_mid_reset", 32'(in_ready), 32'd1);
        repeat (20) @(negedge clk);
        push(32'h4080_0000, 32'h3EF7_59DF, 2'd0);
        idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
